// File: rtl/ipsxe_floating_point_fx2fl_pkg.sv
// Shared constants and types for the fixed-to-float (fx2fl) datapath.
package ipsxe_floating_point_fx2fl_pkg;

  localparam int unsigned FP16_EXP_BIAS = 15;
  localparam int unsigned FP16_EXP_W    = 5;
  localparam int unsigned FP16_MANT_W   = 10;
  localparam int unsigned FP16_EXP_MAX  = 31;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;

  // Depth of the input delay line; must equal the leading-one locator latency.
  localparam int unsigned LOC_LATENCY   = 2;

  typedef struct packed {
    logic        valid;
    logic        sign;
    logic [15:0] mag;
  } fx_word_t;

endpackage

// File: rtl/ipsxe_floating_point_fp16_rne_round_v1_0.sv
// Round-to-nearest-even and binary16 packing of a left-normalized magnitude.
module ipsxe_floating_point_fp16_rne_round_v1_0
  import ipsxe_floating_point_fx2fl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_aclken,
  input  logic        i_valid,
  input  logic        i_sign,
  input  logic        i_zero,
  input  logic [14:0] i_norm_frac,
  input  logic [5:0]  i_exp6,
  output logic        o_valid,
  output logic [15:0] o_result,
  output logic        o_overflow
);

  logic [FP16_MANT_W-1:0] w_m;
  logic [FP16_MANT_W:0]   w_m_inc;
  logic [FP16_MANT_W-1:0] w_mant;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_round_up;
  logic                   w_carry;
  logic [5:0]             w_exp_rnd;
  logic [15:0]            w_result;
  logic                   w_overflow;

  logic                   r_valid;
  logic [15:0]            r_result;
  logic                   r_overflow;

  always_comb begin
    w_m        = i_norm_frac[14:5];
    w_guard    = i_norm_frac[4];
    w_sticky   = |i_norm_frac[3:0];
    w_round_up = w_guard & (w_sticky | w_m[0]);
    w_m_inc    = {1'b0, w_m} + {{FP16_MANT_W{1'b0}}, w_round_up};
    // Mantissa carry-out renormalizes to 1.0 x 2^(e+1).
    w_carry    = w_m_inc[FP16_MANT_W];
    w_mant     = w_carry ? '0 : w_m_inc[FP16_MANT_W-1:0];
    w_exp_rnd  = i_exp6 + {5'd0, w_carry};

    w_overflow = 1'b0;
    w_result   = {i_sign, w_exp_rnd[FP16_EXP_W-1:0], w_mant};
    if (w_exp_rnd >= 6'(FP16_EXP_MAX)) begin
      w_overflow = 1'b1;
      w_result   = {i_sign, FP16_POS_INF[14:0]};
    end else if (i_zero) begin
      w_result   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (i_aclken) begin
      r_valid    <= i_valid;
      r_result   <= w_result;
      r_overflow <= w_overflow;
    end
  end

  assign o_valid    = r_valid;
  assign o_result   = r_result;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// Enable-gated pipeline register with asynchronous active-low reset.
module ipsxe_floating_point_register_v1_0 #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_aclken,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_q <= RST_VAL;
    else if (i_aclken) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ipsxe_floating_point_fx2fl_norm_pack_v1_0.sv
// fx2fl normalize/round/pack: aligns the magnitude with the locator result,
// left-normalizes it and hands it to the RNE rounding/packing stage.
module ipsxe_floating_point_fx2fl_norm_pack_v1_0
  import ipsxe_floating_point_fx2fl_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_aclken,
  input  logic        i_valid,
  input  logic        i_sign,
  input  logic [15:0] i_mag,
  input  logic [3:0]  i_one_location,
  input  logic        i_zero_judge,
  output logic        o_valid,
  output logic [15:0] o_result,
  output logic        o_overflow
);

  fx_word_t    w_dly [LOC_LATENCY+1];
  logic [3:0]  w_sh;
  logic [14:0] w_norm_frac;
  logic [5:0]  w_exp6;

  logic        r_s3_valid;
  logic        r_s3_sign;
  logic        r_s3_zero;
  logic [14:0] r_s3_norm_frac;
  logic [5:0]  r_s3_exp6;

  assign w_dly[0] = '{valid: i_valid, sign: i_sign, mag: i_mag};

  for (genvar k = 0; k < LOC_LATENCY; k++) begin : g_dly
    ipsxe_floating_point_register_v1_0 #(
      .WIDTH   ($bits(fx_word_t)),
      .RST_VAL ('0)
    ) u_dly (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_aclken (i_aclken),
      .i_d      (w_dly[k]),
      .o_q      (w_dly[k+1])
    );
  end

  // The implicit leading one (bit 15 after the shift) is dropped here.
  always_comb begin
    w_sh        = 4'd15 - i_one_location;
    w_norm_frac = 15'(w_dly[LOC_LATENCY].mag << w_sh);
    w_exp6      = {2'b00, i_one_location} + 6'(FP16_EXP_BIAS) - 6'(FRAC_BITS);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3_valid     <= 1'b0;
      r_s3_sign      <= 1'b0;
      r_s3_zero      <= 1'b0;
      r_s3_norm_frac <= '0;
      r_s3_exp6      <= '0;
    end else if (i_aclken) begin
      r_s3_valid <= w_dly[LOC_LATENCY].valid;
      if (w_dly[LOC_LATENCY].valid) begin
        r_s3_sign      <= w_dly[LOC_LATENCY].sign;
        r_s3_zero      <= i_zero_judge;
        r_s3_norm_frac <= w_norm_frac;
        r_s3_exp6      <= w_exp6;
      end
    end
  end

  ipsxe_floating_point_fp16_rne_round_v1_0 u_round (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_aclken    (i_aclken),
    .i_valid     (r_s3_valid),
    .i_sign      (r_s3_sign),
    .i_zero      (r_s3_zero),
    .i_norm_frac (r_s3_norm_frac),
    .i_exp6      (r_s3_exp6),
    .o_valid     (o_valid),
    .o_result    (o_result),
    .o_overflow  (o_overflow)
  );

endmodule
